// File: rtl/image_window_stream.sv
// image_window_stream: raster pixel stream in, interior 3x3 windows out, using two line buffers.
// Define IMAGE_WINDOW_COORD_EN to add win_x/win_y top-left coordinate outputs.
module image_window_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] p4,
    output logic [DATA_W-1:0] p5,
    output logic [DATA_W-1:0] p6,
    output logic [DATA_W-1:0] p7,
    output logic [DATA_W-1:0] p8,
    output logic              m_last
`ifdef IMAGE_WINDOW_COORD_EN
    ,
    output logic [$clog2(IMG_W)-1:0] win_x,
    output logic [$clog2(IMG_H)-1:0] win_y
`endif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] w   [9];
    logic              s_xfer, last_col, last_row, win_ok;

    assign s_ready  = !m_valid || m_ready;
    assign s_xfer   = s_valid && s_ready;
    assign last_col = col == CW'(IMG_W - 1);
    assign last_row = row == RW'(IMG_H - 1);
    assign win_ok   = row >= RW'(2) && col >= CW'(2);
    assign {p0, p1, p2, p3, p4, p5, p6, p7, p8} = {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8]};

    // lb1 holds the previous row, lb2 the one before; unreset, windows are gated until row 2
    always_ff @(posedge clk) begin
        if (s_xfer) begin
            lb2[col] <= lb1[col];
            lb1[col] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            w       <= '{default: '0};
        end else if (s_xfer) begin
            col     <= last_col ? '0 : col + 1'b1;
            row     <= !last_col ? row : last_row ? '0 : row + 1'b1;
            m_valid <= win_ok;
            m_last  <= last_row && last_col;
            for (int k = 0; k < 3; k++) begin
                w[3*k]   <= w[3*k+1];
                w[3*k+1] <= w[3*k+2];
            end
            w[2] <= lb2[col];
            w[5] <= lb1[col];
            w[8] <= s_data;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

`ifdef IMAGE_WINDOW_COORD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            win_x <= '0;
            win_y <= '0;
        end else if (s_xfer) begin
            win_x <= col - CW'(2);
            win_y <= row - RW'(2);
        end
    end
`endif
endmodule
